// File: rtl/lut3d_pkg.sv
// -----------------------------------------------------------------------------
// lut3d_pkg
// Shared definitions for the 3D-LUT configuration streamer:
//   - FSM state encodings (IDLE, LOAD, GEN, DONE)
//   - idx_bits(gs)                 : width of one grid-axis index counter
//   - lut_entries(gs)              : number of table entries, gs^3
//   - identity_val(idx, gs, cd)    : identity-ramp value for one channel
// No ports (package).
// -----------------------------------------------------------------------------
package lut3d_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_GEN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int idx_bits(input int gs);
    return (gs > 2) ? $clog2(gs) : 1;
  endfunction

  function automatic int lut_entries(input int gs);
    return gs * gs * gs;
  endfunction

  // Rounded identity ramp: idx = 0 maps to 0, idx = gs-1 maps to full scale.
  function automatic int identity_val(input int idx, input int gs, input int cd);
    return (idx * ((1 << cd) - 1) + (gs - 1) / 2) / (gs - 1);
  endfunction

endpackage

// File: rtl/lut3d_cfg_fifo.sv
// -----------------------------------------------------------------------------
// lut3d_cfg_fifo
// Synchronous first-word-fall-through FIFO buffering host LUT entries.
// Ports:
//   p_clk, p_rstn   clock, asynchronous active-low reset
//   i_clear         synchronous flush (pointers and count to zero)
//   i_push, i_data  write one entry (ignored when full unless also popping)
//   i_pop           read one entry (ignored when empty)
//   o_data          head entry, valid whenever o_empty is low
//   o_full, o_empty occupancy flags
// -----------------------------------------------------------------------------
module lut3d_cfg_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24
) (
  input  logic         p_clk,
  input  logic         p_rstn,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign o_full  = (cnt_q == (AW + 1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  // Head is read combinationally so an entry pushed at one edge can be
  // popped and registered downstream at the very next edge.
  assign o_data  = mem_q[rd_ptr_q];

  always_comb begin
    // A push into a full FIFO is legal when the same cycle pops.
    push_ok  = i_push && (!o_full || i_pop);
    pop_ok   = i_pop && !o_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
        2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge p_clk or negedge p_rstn) begin
    if (!p_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge p_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/lut3d_cfg_streamer.sv
// -----------------------------------------------------------------------------
// lut3d_cfg_streamer
// Producer of the 3D-LUT configuration stream for the colour mapper. Host
// entries are buffered in a small FIFO and emitted as exactly GS^3 entries in
// grid order (R fastest, then G, then B); o_cfg_last marks the final entry.
// Optional macro LUT3D_IDENTITY_GEN_EN adds i_gen_identity, which makes
// i_start generate an identity table internally instead of loading from host.
// Ports:
//   p_clk, p_rstn        pixel clock, asynchronous active-low reset
//   i_start              one-cycle pulse, begin a table load
//   i_host_data/valid    host entry (R at LSBs, B at MSBs)
//   o_host_ready         host entry accepted when valid && ready
//   i_gen_identity       (macro only) start generates the identity table
//   o_cfg_data/valid     config entry to the mapper, no backpressure
//   o_cfg_last           high with the GS^3-th entry only
//   o_busy               high while loading or generating
//   o_done               one-cycle pulse after the last entry
//   o_err_start          sticky: i_start seen while busy
// -----------------------------------------------------------------------------
module lut3d_cfg_streamer
  import lut3d_pkg::*;
#(
  parameter int GS         = 33,
  parameter int LUT_CD     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                p_clk,
  input  logic                p_rstn,
  input  logic                i_start,
  input  logic [LUT_CD*3-1:0] i_host_data,
  input  logic                i_host_valid,
`ifdef LUT3D_IDENTITY_GEN_EN
  input  logic                i_gen_identity,
`endif
  output logic                o_host_ready,
  output logic [LUT_CD*3-1:0] o_cfg_data,
  output logic                o_cfg_valid,
  output logic                o_cfg_last,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err_start
);
  localparam int DW    = LUT_CD * 3;
  localparam int N_ENT = lut_entries(GS);
  localparam int IW    = idx_bits(GS);
  localparam int CW    = $clog2(N_ENT + 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(GS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_ENT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic [CW-1:0] emit_cnt_q, emit_cnt_d;
  logic [IW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [DW-1:0] cfg_data_q, cfg_data_d;
  logic          cfg_valid_q, cfg_valid_d;
  logic          cfg_last_q, cfg_last_d;
  logic          err_q, err_d;

  logic          in_load, in_gen, busy, start_ok, start_gen;
  logic          emit_full, push, pop, gen_emit, emit, at_max;
  logic          fifo_full, fifo_empty;
  logic [DW-1:0] fifo_rdata, emit_data;

  assign in_load   = (state_q == ST_LOAD);
  assign busy      = in_load || in_gen;
  assign start_ok  = (state_q == ST_IDLE) && i_start;
  assign emit_full = (emit_cnt_q == CNT_MAX);
  assign at_max    = (r_q == IDX_MAX) && (g_q == IDX_MAX) && (b_q == IDX_MAX);

  // Ready depends only on registered state, never on i_host_valid.
  assign o_host_ready = in_load && !fifo_full && (acc_cnt_q != CNT_MAX);
  assign push         = o_host_ready && i_host_valid;
  assign pop          = in_load && !fifo_empty && !emit_full;

`ifdef LUT3D_IDENTITY_GEN_EN
  // Identity ramp per axis, fixed at elaboration; one table serves all three
  // channels since each channel is indexed by its own axis counter.
  logic [LUT_CD-1:0] id_tab [GS];
  for (genvar gi = 0; gi < GS; gi++) begin : g_id_tab
    assign id_tab[gi] = LUT_CD'(identity_val(gi, GS, LUT_CD));
  end
  assign in_gen    = (state_q == ST_GEN);
  assign start_gen = i_gen_identity;
  assign gen_emit  = in_gen && !emit_full;
  assign emit_data = in_gen ? {id_tab[b_q], id_tab[g_q], id_tab[r_q]} : fifo_rdata;
`else
  assign in_gen    = 1'b0;
  assign start_gen = 1'b0;
  assign gen_emit  = 1'b0;
  assign emit_data = fifo_rdata;
`endif

  assign emit = pop || gen_emit;

  lut3d_cfg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DW)
  ) u_fifo (
    .p_clk   (p_clk),
    .p_rstn  (p_rstn),
    .i_clear (start_ok),
    .i_push  (push),
    .i_data  (i_host_data),
    .i_pop   (pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = start_gen ? ST_GEN : ST_LOAD;
      ST_DONE: state_d = ST_IDLE;
      // LOAD or GEN: leave once every entry has been emitted, so DONE
      // follows the cycle that carries o_cfg_last.
      default: if (emit_full) state_d = ST_DONE;
    endcase
  end

  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    err_d       = err_q;
    cfg_valid_d = emit;
    cfg_last_d  = emit && at_max;
    cfg_data_d  = emit ? emit_data : cfg_data_q;
    if (start_ok) begin
      acc_cnt_d  = '0;
      emit_cnt_d = '0;
      r_d        = '0;
      g_d        = '0;
      b_d        = '0;
      err_d      = 1'b0;
    end else begin
      if (i_start && busy) err_d = 1'b1;
      if (push) acc_cnt_d = acc_cnt_q + CW'(1);
      if (emit) begin
        emit_cnt_d = emit_cnt_q + CW'(1);
        // R is fastest; each axis wraps at GS-1 and carries upward.
        if (r_q != IDX_MAX) begin
          r_d = r_q + IW'(1);
        end else begin
          r_d = '0;
          if (g_q != IDX_MAX) begin
            g_d = g_q + IW'(1);
          end else begin
            g_d = '0;
            b_d = (b_q == IDX_MAX) ? '0 : b_q + IW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge p_clk or negedge p_rstn) begin
    if (!p_rstn) begin
      state_q     <= ST_IDLE;
      acc_cnt_q   <= '0;
      emit_cnt_q  <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
      cfg_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      cfg_data_q  <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_last_q  <= cfg_last_d;
      err_q       <= err_d;
    end
  end

  assign o_cfg_data  = cfg_data_q;
  assign o_cfg_valid = cfg_valid_q;
  assign o_cfg_last  = cfg_last_q;
  assign o_busy      = busy;
  assign o_done      = (state_q == ST_DONE);
  assign o_err_start = err_q;

endmodule

// File: tb/tb_lut3d_cfg_streamer.sv
// -----------------------------------------------------------------------------
// tb_lut3d_cfg_streamer
// Self-checking bench for lut3d_cfg_streamer with GS=17, LUT_CD=8, FIFO=16.
// A queue-based reference model tracks accepted host entries, the buffer
// contents and the emitted count; every cycle the DUT is compared with it.
// Build with +define+LUT3D_IDENTITY_GEN_EN to also exercise identity GEN.
// -----------------------------------------------------------------------------
module tb_lut3d_cfg_streamer;
  localparam int GS         = 17;
  localparam int LUT_CD     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int N          = GS * GS * GS;
  localparam int DW         = 3 * LUT_CD;

  logic          p_clk = 1'b0;
  logic          p_rstn = 1'b0;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_host_data = '0;
  logic          i_host_valid = 1'b0;
`ifdef LUT3D_IDENTITY_GEN_EN
  logic          i_gen_identity = 1'b0;
`endif
  logic          o_host_ready, o_cfg_valid, o_cfg_last, o_busy, o_done, o_err_start;
  logic [DW-1:0] o_cfg_data;

  lut3d_cfg_streamer #(
    .GS         (GS),
    .LUT_CD     (LUT_CD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .p_clk          (p_clk),
    .p_rstn         (p_rstn),
    .i_start        (i_start),
    .i_host_data    (i_host_data),
    .i_host_valid   (i_host_valid),
`ifdef LUT3D_IDENTITY_GEN_EN
    .i_gen_identity (i_gen_identity),
`endif
    .o_host_ready   (o_host_ready),
    .o_cfg_data     (o_cfg_data),
    .o_cfg_valid    (o_cfg_valid),
    .o_cfg_last     (o_cfg_last),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err_start    (o_err_start)
  );

  initial forever #5 p_clk = ~p_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 load, 2 done.
  int            m_st = 0;
  int            m_acc = 0;
  int            m_pop = 0;
  bit            m_err = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_fifo [$];
  int            run_len = 0;
  int            last_cnt = 0;
  bit            chk_contig = 1'b0;

  typedef struct {
    bit            start;
    bit            hv;
    logic [DW-1:0] hd;
    bit            e_ready;
    bit            e_busy;
    bit            e_valid;
    bit            e_err;
    logic [DW-1:0] e_data;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check ready against the model, let the edge happen,
  // advance the model by the spec rules and compare all registered outputs.
  task automatic step();
    bit            hs, pop, start_in, exp_last;
    int            fsz, pop_pre;
    logic [DW-1:0] hd;
    fsz     = m_fifo.size();
    pop_pre = m_pop;
    check("host_ready", 64'(o_host_ready), 64'(m_st == 1 && fsz < FIFO_DEPTH && m_acc < N));
    hs       = (m_st == 1) && (fsz < FIFO_DEPTH) && (m_acc < N) && i_host_valid;
    pop      = (m_st == 1) && (fsz > 0) && (m_pop < N);
    hd       = i_host_data;
    start_in = i_start;
    @(posedge p_clk);
    #1;
    exp_last = 1'b0;
    if (pop) begin
      m_data = m_fifo.pop_front();
      m_pop++;
      exp_last = (m_pop == N);
    end
    if (hs) begin
      m_fifo.push_back(hd);
      m_acc++;
    end
    case (m_st)
      0: if (start_in) begin
        m_st = 1; m_acc = 0; m_pop = 0; m_err = 1'b0; m_fifo.delete();
      end
      1: begin
        if (start_in) m_err = 1'b1;
        if (pop_pre == N) m_st = 2;
      end
      default: m_st = 0;
    endcase
    if (o_cfg_valid === 1'b1) run_len++; else run_len = 0;
    if (o_cfg_last === 1'b1) last_cnt++;
    check("outputs{busy,done,err,valid,last,data}",
          64'({o_busy, o_done, o_err_start, o_cfg_valid, o_cfg_last, o_cfg_data}),
          64'({m_st == 1, m_st == 2, m_err, pop, exp_last, m_data}));
    if (chk_contig && o_cfg_last === 1'b1) check("contig_run", 64'(run_len), 64'(N));
  endtask

  task automatic host_drive(input bit gaps);
    i_host_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    i_host_data  = gaps ? DW'($urandom) : DW'(m_acc);
  endtask

  task automatic start_load();
    i_start = 1'b1; i_host_valid = 1'b0;
    last_cnt = 0;
    step();
    i_start = 1'b0;
  endtask

  task automatic run_load(input bit gaps, input bit err_pulse, input int stop_pop, input int budget);
    int c;
    bit pulsed;
    c = 0; pulsed = 1'b0;
    while (m_st != 0 && c < budget && !(stop_pop > 0 && m_pop >= stop_pop)) begin
      host_drive(gaps);
      i_start = err_pulse && !pulsed && (m_acc == 100);
      if (i_start) pulsed = 1'b1;
      step();
      c++;
    end
    i_start = 1'b0; i_host_valid = 1'b0;
    check("loop_budget", 64'(c < budget), 64'(1));
  endtask

`ifdef LUT3D_IDENTITY_GEN_EN
  function automatic logic [LUT_CD-1:0] id_ref(input int idx);
    return LUT_CD'((idx * ((1 << LUT_CD) - 1) + (GS - 1) / 2) / (GS - 1));
  endfunction
  int            gn, gr, gg, gb;
  logic [DW-1:0] gexp;
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 24'hAAAAAA, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    vecs[1] = '{1'b0, 1'b1, 24'h555555, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    vecs[2] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    vecs[3] = '{1'b0, 1'b1, 24'h000001, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
    vecs[4] = '{1'b0, 1'b1, 24'h000002, 1'b1, 1'b1, 1'b1, 1'b0, 24'h1};
    vecs[5] = '{1'b1, 1'b1, 24'h000003, 1'b1, 1'b1, 1'b1, 1'b1, 24'h2};
    vecs[6] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 1'b1, 24'h3};
    vecs[7] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0};

    // Reset state
    repeat (3) @(posedge p_clk);
    #1;
    check("reset_outputs", 64'({o_host_ready, o_busy, o_done, o_err_start, o_cfg_valid, o_cfg_last, o_cfg_data}), 64'(0));
    p_rstn = 1'b1;
    step();

    // 1) back-to-back load of entry indices, then host valid held in idle
    chk_contig = 1'b1;
    start_load();
    run_load(1'b0, 1'b0, 0, N + 100);
    chk_contig = 1'b0;
    check("b2b_last_count", 64'(last_cnt), 64'(1));
    for (int i = 0; i < 6; i++) begin
      i_host_valid = 1'b1; i_host_data = DW'($urandom);
      step();
    end
    i_host_valid = 1'b0;

    // 2) random host gaps with an i_start while busy at entry 100
    start_load();
    run_load(1'b1, 1'b1, 0, 4 * N);
    check("gaps_last_count", 64'(last_cnt), 64'(1));
    check("err_sticky_after_done", 64'(o_err_start), 64'(1));

    // 3) table-driven start sequence: idle host ignored, start clears error,
    //    one-cycle latency, i_start while busy flags error
    last_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      i_start = vecs[i].start; i_host_valid = vecs[i].hv; i_host_data = vecs[i].hd;
      check("vec_ready", 64'(o_host_ready), 64'(vecs[i].e_ready));
      step();
      check("vec_busy_valid_err", 64'({o_busy, o_cfg_valid, o_err_start}),
            64'({vecs[i].e_busy, vecs[i].e_valid, vecs[i].e_err}));
      if (vecs[i].e_valid) check("vec_data", 64'(o_cfg_data), 64'(vecs[i].e_data));
    end
    i_start = 1'b0;
    run_load(1'b1, 1'b0, 0, 4 * N);
    check("vec_load_last_count", 64'(last_cnt), 64'(1));

    // 4) asynchronous reset in the middle of a load
    start_load();
    run_load(1'b0, 1'b0, 2000, N + 100);
    #2 p_rstn = 1'b0;
    #1;
    check("midload_reset_outputs", 64'({o_host_ready, o_busy, o_done, o_err_start, o_cfg_valid, o_cfg_last, o_cfg_data}), 64'(0));
    @(posedge p_clk);
    #1;
    check("reset_hold_outputs", 64'({o_host_ready, o_busy, o_done, o_cfg_valid, o_cfg_data}), 64'(0));
    check("trunc_no_last", 64'(last_cnt), 64'(0));
    p_rstn = 1'b1;
    m_st = 0; m_acc = 0; m_pop = 0; m_err = 1'b0; m_data = '0; m_fifo.delete();
    step();

    // 5) full load after the reset
    chk_contig = 1'b1;
    start_load();
    run_load(1'b0, 1'b0, 0, N + 100);
    chk_contig = 1'b0;
    check("post_reset_last_count", 64'(last_cnt), 64'(1));

`ifdef LUT3D_IDENTITY_GEN_EN
    // 6) identity generation
    gn = 0;
    i_gen_identity = 1'b1; i_start = 1'b1;
    @(posedge p_clk);
    #1;
    i_gen_identity = 1'b0; i_start = 1'b0;
    check("gen_host_ready", 64'(o_host_ready), 64'(0));
    for (int c = 0; c < N + 20 && gn < N; c++) begin
      @(posedge p_clk);
      #1;
      if (o_cfg_valid === 1'b1) begin
        gr = gn % GS; gg = (gn / GS) % GS; gb = gn / (GS * GS);
        gexp = {id_ref(gb), id_ref(gg), id_ref(gr)};
        check("gen_data", 64'(o_cfg_data), 64'(gexp));
        check("gen_last", 64'(o_cfg_last), 64'(gn == N - 1));
        if (gn == 0)     check("gen_entry0", 64'(o_cfg_data), 64'(24'h000000));
        if (gn == 1)     check("gen_idx1_r", 64'(o_cfg_data[7:0]), 64'(16));
        if (gn == 8)     check("gen_idx8_r", 64'(o_cfg_data[7:0]), 64'(128));
        if (gn == 16)    check("gen_idx16_r", 64'(o_cfg_data[7:0]), 64'(255));
        if (gn == N - 1) check("gen_last_entry", 64'(o_cfg_data), 64'(24'hFFFFFF));
        gn++;
      end
    end
    check("gen_count", 64'(gn), 64'(N));
    @(posedge p_clk);
    #1;
    check("gen_done", 64'({o_done, o_busy, o_cfg_valid}), 64'(3'b100));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
